// File: rtl/decoder_sel_pkg.sv
`default_nettype none
// ============================================================================
// Package     : decoder_sel_pkg
// Description : Shared types and default constants for the decoder select
//               sequencer (FSM state encoding, default sizing, scan
//               direction codes).
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_sel_pkg;

  // Explicit 2-bit encoding; the unused code 2'd3 is steered back to MANUAL.
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam int DEF_WIDTH           = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SCAN_DIV        = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : decoder_sel_pkg
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : One-bit switch conditioner. A two-flop synchronizer feeds a
//               disagreement counter; the debounced level toggles only after
//               the synchronized level has differed from it for
//               DEBOUNCE_CYCLES consecutive cycles.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               i_raw   - raw asynchronous switch level
//               o_deb   - debounced level (registered)
//               o_idle  - counter is zero and synchronized level == debounced
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
  import decoder_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb,
  output logic o_idle
);

  localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   c_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_deb) begin
        // Accept the new level on the edge where the count would reach
        // DEBOUNCE_CYCLES; the counter never actually holds that value.
        if (r_cnt == c_LAST) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any agreement discards a partially counted glitch.
        r_cnt <= '0;
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_idle = (r_cnt == '0) && (r_sync2 == r_deb);

endmodule : switch_debounce
`default_nettype wire

// File: rtl/decoder_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decoder_select_sequencer
// Description : Produces the select code for the 3-to-8 LED decoder. In
//               MANUAL mode the code follows the debounced switches; in AUTO
//               mode it steps up or down once every SCAN_DIV clocks and can
//               be paused.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               sw_in        - raw switch levels [WIDTH]
//               mode_auto    - 0 = MANUAL, 1 = AUTO scan
//               scan_dir     - AUTO direction, 0 = up, 1 = down
//               pause        - freezes AUTO scanning while high
//               sel_out      - registered select code [WIDTH]
//               sel_changed  - pulse in first cycle sel_out holds a new value
//               stable       - all debouncers idle (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_select_sequencer
  import decoder_sel_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SCAN_DIV        = DEF_SCAN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             mode_auto,
  input  logic             scan_dir,
  input  logic             pause,
  output logic [WIDTH-1:0] sel_out,
  output logic             sel_changed,
  output logic             stable
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] c_PRE_LAST = PW'(SCAN_DIV - 1);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_idle;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (sw_in[gi]),
        .o_deb  (w_deb[gi]),
        .o_idle (w_idle[gi])
      );
    end
  endgenerate

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PW-1:0]    r_pre;
  logic [PW-1:0]    w_pre_nxt;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] w_sel_nxt;
  logic             r_chg;
  logic             r_stable;

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_sel_nxt   = r_sel;
    case (r_state)
      MANUAL: begin
        if (mode_auto) begin
          // Entry cycle holds the current code and restarts the interval.
          w_state_nxt = AUTO;
          w_pre_nxt   = '0;
        end else begin
          w_sel_nxt = w_deb;
        end
      end
      AUTO, PAUSED: begin
        if (!mode_auto) begin
          // Leaving scan wins over pause; no step in the exit cycle.
          w_state_nxt = MANUAL;
          w_pre_nxt   = '0;
        end else if (pause) begin
          // Frozen: a terminal count arriving now is simply not taken.
          w_state_nxt = PAUSED;
        end else begin
          // The resume cycle already counts, continuing from the frozen value.
          w_state_nxt = AUTO;
          if (r_pre == c_PRE_LAST) begin
            w_pre_nxt = '0;
            w_sel_nxt = (scan_dir == DIR_DOWN) ? (r_sel - 1'b1) : (r_sel + 1'b1);
          end else begin
            w_pre_nxt = r_pre + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = MANUAL;
        w_pre_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MANUAL;
      r_pre    <= '0;
      r_sel    <= '0;
      r_chg    <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pre    <= w_pre_nxt;
      r_sel    <= w_sel_nxt;
      r_chg    <= (w_sel_nxt != r_sel);
      r_stable <= &w_idle;
    end
  end

  assign sel_out     = r_sel;
  assign sel_changed = r_chg;
  assign stable      = r_stable;

endmodule : decoder_select_sequencer
`default_nettype wire

// File: tb/tb_decoder_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_select_sequencer
// Description : Directed scenarios followed by randomized traffic, every cycle
//               compared against a behavioural model of the select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_select_sequencer;

  localparam int W  = 3;
  localparam int DB = 4;
  localparam int SD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic         mode_auto;
  logic         scan_dir;
  logic         pause;
  logic [W-1:0] sel_out;
  logic         sel_changed;
  logic         stable;

  decoder_select_sequencer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .SCAN_DIV        (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_in       (sw_in),
    .mode_auto   (mode_auto),
    .scan_dir    (scan_dir),
    .pause       (pause),
    .sel_out     (sel_out),
    .sel_changed (sel_changed),
    .stable      (stable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: synchronized samples, per-bit disagreement run length,
  // a scanning flag and a tick count within the current scan interval.
  logic [W-1:0] m_s1, m_s2, m_deb, m_sel;
  int           m_run [W];
  bit           m_auto;
  int           m_pre;
  bit           m_chg, m_stable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] deb_old;
    logic [W-1:0] new_sel;
    bit           st;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_sel = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
      m_auto = 0; m_pre = 0; m_chg = 0; m_stable = 0;
    end else begin
      deb_old = m_deb;
      st = 1;
      for (int b = 0; b < W; b++)
        if (m_run[b] != 0 || m_s2[b] != m_deb[b]) st = 0;
      for (int b = 0; b < W; b++) begin
        if (m_s2[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_deb[b] = ~m_deb[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
      new_sel = m_sel;
      if (!m_auto) begin
        if (mode_auto) begin
          m_auto = 1;
          m_pre  = 0;
        end else begin
          new_sel = deb_old;
        end
      end else if (!mode_auto) begin
        m_auto = 0;
        m_pre  = 0;
      end else if (!pause) begin
        m_pre++;
        if (m_pre == SD) begin
          m_pre   = 0;
          new_sel = W'((int'(m_sel) + (scan_dir ? (1 << W) - 1 : 1)) % (1 << W));
        end
      end
      m_chg    = (new_sel != m_sel);
      m_sel    = new_sel;
      m_stable = st;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sel_out", 32'(sel_out), 32'(m_sel));
    chk("model_sel_changed", 32'(sel_changed), 32'(m_chg));
    chk("model_stable", 32'(stable), 32'(m_stable));
  endtask

  initial begin
    int pulses;
    int n;
    int hold;
    bit seen_chg;
    bit seen_nz;

    // Reset with switches and AUTO request active
    rst = 1'b1; sw_in = 3'b101; mode_auto = 1'b1; scan_dir = 1'b0; pause = 1'b0;
    step(); step();
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_chg", 32'(sel_changed), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);

    rst = 1'b0; mode_auto = 1'b0; sw_in = 3'b000;
    repeat (10) step();
    chk("idle_stable", 32'(stable), 32'd1);

    // Manual settle: visible on the 7th edge, single pulse
    sw_in = 3'b101;
    repeat (6) step();
    chk("manual_hold6", 32'(sel_out), 32'd0);
    step();
    chk("manual_edge7", 32'(sel_out), 32'd5);
    chk("manual_chg", 32'(sel_changed), 32'd1);
    step();
    chk("manual_chg_once", 32'(sel_changed), 32'd0);

    // Glitch shorter than the debounce window
    sw_in = 3'b000;
    repeat (12) step();
    seen_chg = 0; seen_nz = 0;
    sw_in = 3'b001;
    repeat (3) begin step(); seen_chg |= sel_changed; seen_nz |= (sel_out != 0); end
    sw_in = 3'b000;
    repeat (12) begin step(); seen_chg |= sel_changed; seen_nz |= (sel_out != 0); end
    chk("glitch_sel", 32'(seen_nz), 32'd0);
    chk("glitch_chg_never", 32'(seen_chg), 32'd0);
    chk("glitch_stable", 32'(stable), 32'd1);

    // AUTO up with wrap from 110
    sw_in = 3'b110;
    repeat (10) step();
    chk("pre_auto_sel", 32'(sel_out), 32'd6);
    mode_auto = 1'b1; scan_dir = 1'b0;
    step();
    pulses = 0;
    repeat (8) begin step(); pulses += int'(sel_changed); end
    chk("up_step1", 32'(sel_out), 32'd7);
    repeat (8) begin step(); pulses += int'(sel_changed); end
    chk("up_wrap", 32'(sel_out), 32'd0);
    chk("up_pulses", 32'(pulses), 32'd2);

    // AUTO down with pause on edges 5..14 after entry
    mode_auto = 1'b0; sw_in = 3'b000;
    repeat (10) step();
    chk("pre_down_sel", 32'(sel_out), 32'd0);
    mode_auto = 1'b1; scan_dir = 1'b1;
    step();
    repeat (4) step();
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    repeat (3) step();
    chk("pause_hold17", 32'(sel_out), 32'd0);
    step();
    chk("pause_step18", 32'(sel_out), 32'd7);
    chk("pause_step18_chg", 32'(sel_changed), 32'd1);

    // Pause exactly on a terminal count
    repeat (7) step();
    pause = 1'b1;
    step();
    chk("suppress_sel", 32'(sel_out), 32'd7);
    chk("suppress_chg", 32'(sel_changed), 32'd0);
    pause = 1'b0;
    step();
    chk("resume_step", 32'(sel_out), 32'd6);

    // Mid-operation reset at 011
    n = 0;
    while (m_sel != 3'b011 && n < 40) begin step(); n++; end
    chk("reach_011", 32'(sel_out), 32'd3);
    rst = 1'b1; mode_auto = 1'b0;
    step();
    chk("mid_rst_sel", 32'(sel_out), 32'd0);
    chk("mid_rst_chg", 32'(sel_changed), 32'd0);
    chk("mid_rst_stable", 32'(stable), 32'd0);
    rst = 1'b0; sw_in = 3'b010;
    repeat (8) step();
    chk("post_rst_manual", 32'(sel_out), 32'd2);

    // Exit with pause still high: MANUAL wins, deb appears one edge later
    mode_auto = 1'b1; pause = 1'b1;
    step(); step();
    sw_in = 3'b100;
    repeat (10) step();
    chk("paused_hold", 32'(sel_out), 32'd2);
    mode_auto = 1'b0;
    step();
    chk("exit_cycle_hold", 32'(sel_out), 32'd2);
    step();
    chk("exit_deb", 32'(sel_out), 32'd4);
    chk("exit_chg", 32'(sel_changed), 32'd1);
    pause = 1'b0;

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sw_in = W'($urandom);
        hold  = int'($urandom_range(1, 12));
      end else begin
        hold--;
      end
      if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      if ($urandom_range(0, 9) == 0)  scan_dir = ~scan_dir;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_select_sequencer
`default_nettype wire
